// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type, iteration count and small sign helpers.
package muldiv_pkg;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_ITERS = 32;

  // Iteration counter is loaded with the index of the last step and counts down to zero.
  localparam logic [4:0] MULDIV_CNT_LAST = 5'(MULDIV_ITERS - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Two's-complement negate of a word when neg is set.
  function automatic logic [MULDIV_XLEN-1:0] cond_neg_word(input logic [MULDIV_XLEN-1:0] v,
                                                           input logic neg);
    cond_neg_word = neg ? (~v + {{(MULDIV_XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement negate of a double word when neg is set.
  function automatic logic [2*MULDIV_XLEN-1:0] cond_neg_dword(input logic [2*MULDIV_XLEN-1:0] v,
                                                              input logic neg);
    cond_neg_dword = neg ? (~v + {{(2*MULDIV_XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic rs1_is_signed(input logic [2:0] op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: rs1_is_signed = 1'b1;
      default:                            rs1_is_signed = 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic rs2_is_signed(input logic [2:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: rs2_is_signed = 1'b1;
      default:                 rs2_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module muldiv_div_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] trial;

  // Trial subtraction; the difference always fits in XLEN bits when it is taken.
  always_comb begin
    trial = {rem_in, dividend_bit};
    if (trial >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = trial[XLEN-1:0] - divisor;
    end else begin
      q_bit   = 1'b0;
      rem_out = trial[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and
// register-file writeback outputs. Operands are reduced to magnitudes at
// accept; the sign is restored on the final step.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle 33x33 signed
// multiplier instead of the 32-cycle shift-add multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_en,
  output logic [4:0]      wb_rd_addr
);

  state_t state, state_next;

  logic [2:0]        lat_op;
  logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [4:0]        iter_cnt;
  logic              neg_main;  // negate product / quotient
  logic              neg_rem;   // remainder follows dividend sign

  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_result;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_raw, prod_fix;
  logic [XLEN-1:0]   rem_step;
  logic              q_step;
  logic              mul_last, div_last;
  logic [XLEN-1:0]   mul_result, div_result;

  logic              accept, load_special, finish_mul, finish_div;
  logic [4:0]        rd_next;

  // Operand decode: sign flags, magnitudes and division corner cases.
  always_comb begin
    sign1    = rs1_is_signed(op) & rs1_data[XLEN-1];
    sign2    = rs2_is_signed(op) & rs2_data[XLEN-1];
    mag1     = cond_neg_word(rs1_data, sign1);
    mag2     = cond_neg_word(rs2_data, sign2);
    div_zero = (rs2_data == {XLEN{1'b0}});
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rs2_data == {XLEN{1'b1}});
    special  = op[2] & (div_zero | div_ovf);
    if (div_zero) begin
      special_result = op[1] ? rs1_data : {XLEN{1'b1}};
    end else if (div_ovf) begin
      special_result = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      special_result = {XLEN{1'b0}};
    end
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (acc[2*XLEN-1:XLEN]),
    .divisor      (opnd),
    .dividend_bit (acc[XLEN-1]),
    .rem_out      (rem_step),
    .q_bit        (q_step)
  );

  // Next accumulator values for one shift-add or restoring-division iteration.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_next = {rem_step, acc[XLEN-2:0], q_step};
    div_last = (iter_cnt == 5'd0);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;

  // Single-cycle product of the two magnitudes through a 33x33 signed multiplier.
  always_comb begin
    fast_prod = $signed({1'b0, opnd}) * $signed({1'b0, acc[XLEN-1:0]});
    prod_raw  = fast_prod[2*XLEN-1:0];
    mul_last  = 1'b1;
  end
`else
  // Shift-add product is complete after the iteration with counter zero.
  always_comb begin
    prod_raw = mul_next;
    mul_last = (iter_cnt == 5'd0);
  end
`endif

  // Sign restoration and selection of the architectural result word.
  always_comb begin
    prod_fix   = cond_neg_dword(prod_raw, neg_main);
    mul_result = (lat_op == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_result = lat_op[1] ? cond_neg_word(div_next[2*XLEN-1:XLEN], neg_rem)
                           : cond_neg_word(div_next[XLEN-1:0], neg_main);
  end

  // Next-state logic; kill overrides every transition and suppresses result update.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    load_special = 1'b0;
    finish_mul   = 1'b0;
    finish_div   = 1'b0;
    if (kill) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            accept = 1'b1;
            if (special) begin
              load_special = 1'b1;
              state_next   = S_DONE;
            end else if (op[2]) begin
              state_next = S_DIV;
            end else begin
              state_next = S_MUL;
            end
          end else begin
            state_next = S_IDLE;
          end
        end
        S_MUL: begin
          if (mul_last) begin
            finish_mul = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_MUL;
          end
        end
        S_DIV: begin
          if (div_last) begin
            finish_div = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_DIV;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
    rd_next = accept ? rd_addr : wb_rd_addr;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch at accept and per-cycle iteration of the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_op   <= OP_MUL;
      opnd     <= {XLEN{1'b0}};
      acc      <= {(2*XLEN){1'b0}};
      iter_cnt <= 5'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (accept) begin
      lat_op   <= op;
      iter_cnt <= MULDIV_CNT_LAST;
      neg_main <= sign1 ^ sign2;
      neg_rem  <= sign1;
      if (op[2]) begin
        opnd <= mag2;
        acc  <= {{XLEN{1'b0}}, mag1};
      end else begin
        opnd <= mag1;
        acc  <= {{XLEN{1'b0}}, mag2};
      end
    end else if ((state == S_MUL) && !kill) begin
      acc      <= mul_next;
      iter_cnt <= iter_cnt - 5'd1;
    end else if ((state == S_DIV) && !kill) begin
      acc      <= div_next;
      iter_cnt <= iter_cnt - 5'd1;
    end
  end

  // Registered handshake and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_en      <= 1'b0;
      wb_rd_addr <= 5'd0;
      result     <= {XLEN{1'b0}};
    end else begin
      busy       <= (state_next == S_MUL) || (state_next == S_DIV);
      done       <= (state_next == S_DONE);
      wb_en      <= (state_next == S_DONE) && (rd_next != 5'd0);
      wb_rd_addr <= rd_next;
      if (load_special) begin
        result <= special_result;
      end else if (finish_mul) begin
        result <= mul_result;
      end else if (finish_div) begin
        result <= div_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, handshake corner
// cases and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        wb_en;
  logic [4:0]  wb_rd_addr;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_result;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_addr    (rd_addr),
    .kill       (kill),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .wb_en      (wb_en),
    .wb_rd_addr (wb_rd_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result from RV32M arithmetic rules using wide integer math.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    case (f3)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : (a % b);
    endcase
  endfunction

  // Cycle (after the accept edge) in which done is expected.
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 2;
`else
      return 33;
`endif
    end
    if (b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one request and return #1 after the accept edge (cycle 1).
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cyc is -1 when the budget expires.
  task automatic wait_done(input int from_cyc, output int cyc);
    int c;
    c   = from_cyc;
    cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        cyc = c;
        break;
      end
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat, cyc;
    lat = exp_lat(f3, a, b);
    launch(f3, a, b, rd);
    check({tag, ".busy_c1"}, 32'(busy), 32'(lat > 1));
    wait_done(1, cyc);
    check({tag, ".done_cycle"}, 32'(cyc), 32'(lat));
    check({tag, ".result"}, result, exp);
    check({tag, ".wb_en"}, 32'(wb_en), 32'(rd != 5'd0));
    check({tag, ".wb_rd_addr"}, 32'(wb_rd_addr), 32'(rd));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    last_result = exp;
  endtask

  initial begin
    int          cyc, pulses, r;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;

    n_checks = 0; n_fail = 0; last_result = 32'd0;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_addr = 5'd0;

    #2;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.wb_en", 32'(wb_en), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
    do_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
    do_op("remu_5_0", 3'd7, 32'd5, 32'd0, 5'd14, 32'd5);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
    do_op("mul_rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12);

    // Start while busy is ignored; start during the done cycle is taken one cycle later
    launch(3'd0, 32'd1000, 32'd1234, 5'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_data = 32'd99; rs2_data = 32'd9; rd_addr = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_start.busy", 32'(busy), 32'd1);
    wait_done(5, cyc);
    check("busy_start.done_cycle", 32'(cyc), 32'(exp_lat(3'd0, 32'd1000, 32'd1234)));
    check("busy_start.result", result, 32'd1_234_000);
    check("busy_start.wb_rd_addr", 32'(wb_rd_addr), 32'd3);
    start = 1'b1; op = 3'd5; rs1_data = 32'd99; rs2_data = 32'd9; rd_addr = 5'd4;
    @(posedge clk);
    #1;
    check("start_in_done.ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_after_done.busy", 32'(busy), 32'd1);
    wait_done(1, cyc);
    check("start_after_done.done_cycle", 32'(cyc), 32'd33);
    check("start_after_done.result", result, 32'd11);
    last_result = 32'd11;
    @(posedge clk);
    #1;

    // kill in cycle 10
    launch(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill.busy", 32'(busy), 32'd0);
    check("kill.done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("kill.no_done", 32'(pulses), 32'd0);
    check("kill.result_held", result, last_result);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      r  = $urandom_range(0, 5);
      if (r == 0) b = 32'd0;
      else if (r == 1) b = 32'($urandom_range(1, 15));
      else if (r == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      do_op("rand", f3, a, b, rd, ref_model(f3, a, b));
    end

    // Asynchronous reset mid-operation
    launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst.busy", 32'(busy), 32'd0);
    check("async_rst.done", 32'(done), 32'd0);
    check("async_rst.result", result, 32'd0);
    check("async_rst.wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd22, ref_model(3'd6, 32'hFFFF_FF9C, 32'd7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
